// File: rtl/jk_fsm_bank.sv
// Bank of independent JK Moore machines (OFF/LOCK/ON) with a programmable
// conflict mode, a minimum-on dwell lock and registered rise/fall pulses.
module jk_fsm_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] j,
  input  logic [CHANNELS-1:0] k,
  input  logic [1:0]          mode,
  input  logic [CNT_W-1:0]    min_on,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] locked
);

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StLock = 2'd1,
    StOn   = 2'd2
  } state_e;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] on_cond, off_cond;

  // Conflict resolution: mode[1] makes k veto turn-on, mode[0] makes j veto turn-off.
  always_comb begin
    on_cond  = mode[1] ? (j & ~k) : j;
    off_cond = mode[0] ? (k & ~j) : k;
  end

  // Per-channel next state, dwell counter and edge-pulse generation.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StOff: begin
          if (on_cond[i]) begin
            if (min_on == '0) begin
              state_d[i] = StOn;
            end else begin
              state_d[i] = StLock;
              cnt_d[i]   = min_on;
            end
          end
        end
        StLock: begin
          // j/k ignored; count is the one latched on entry.
          if (cnt_q[i] == CNT_W'(1)) begin
            state_d[i] = StOn;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        StOn: begin
          if (off_cond[i]) begin
            state_d[i] = StOff;
          end
        end
        default: begin
          state_d[i] = StOff;
        end
      endcase
      rise_d[i] = (state_q[i] == StOff) && (state_d[i] != StOff);
      fall_d[i] = (state_q[i] == StOn)  && (state_d[i] == StOff);
    end
  end

  // State, counter and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= StOff;
        cnt_q[i]   <= '0;
      end
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Moore output decode straight from the state and pulse flops.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      dout[i]   = (state_q[i] != StOff);
      locked[i] = (state_q[i] == StLock);
    end
    rise = rise_q;
    fall = fall_q;
  end

endmodule

// File: tb/tb_jk_fsm_bank.sv
// Scoreboard bench for jk_fsm_bank: directed vectors with hand-computed
// expectations, then random stimulus checked against a behavioural model.
module tb_jk_fsm_bank;

  typedef struct packed {
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] lock;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] j, k;
  logic [1:0] mode;
  logic [3:0] min_on;
  logic [3:0] dout, rise, fall, locked;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;

  // Behavioural model state: 0=off, 1=lock, 2=on.
  int ms[4];
  int mc[4];
  bit mr[4];
  bit mf[4];

  jk_fsm_bank #(
    .CHANNELS(4),
    .CNT_W   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .j     (j),
    .k     (k),
    .mode  (mode),
    .min_on(min_on),
    .dout  (dout),
    .rise  (rise),
    .fall  (fall),
    .locked(locked)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_step(bit rst, logic [3:0] jj, logic [3:0] kk,
                                      logic [1:0] md, logic [3:0] mn);
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      if (!rst) begin
        ms[c] = 0; mc[c] = 0; mr[c] = 0; mf[c] = 0;
      end else begin
        mr[c] = 0;
        mf[c] = 0;
        if (ms[c] == 0) begin
          bit on;
          on = (md >= 2) ? (jj[c] && !kk[c]) : jj[c];
          if (on) begin
            mr[c] = 1;
            if (mn == 0) ms[c] = 2;
            else begin
              ms[c] = 1;
              mc[c] = int'(mn);
            end
          end
        end else if (ms[c] == 1) begin
          if (mc[c] == 1) ms[c] = 2;
          else mc[c] = mc[c] - 1;
        end else begin
          bit off;
          off = (md == 1 || md == 3) ? (kk[c] && !jj[c]) : kk[c];
          if (off) begin
            ms[c] = 0;
            mf[c] = 1;
          end
        end
      end
      e.dout[c] = (ms[c] != 0);
      e.lock[c] = (ms[c] == 1);
      e.rise[c] = mr[c];
      e.fall[c] = mf[c];
    end
    return e;
  endfunction

  // Directed step: drive inputs, queue the hand-computed result, advance one cycle.
  task automatic dstep(bit rst, logic [3:0] jj, logic [3:0] kk, logic [1:0] md,
                       logic [3:0] mn, logic [3:0] ed, logic [3:0] er,
                       logic [3:0] ef, logic [3:0] el);
    exp_t e;
    exp_t unused_m;
    reset = rst; j = jj; k = kk; mode = md; min_on = mn;
    unused_m = model_step(rst, jj, kk, md, mn);
    e.dout = ed; e.rise = er; e.fall = ef; e.lock = el;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Random step: expectation comes from the behavioural model.
  task automatic rstep();
    bit         rst;
    logic [3:0] jj, kk, mn;
    logic [1:0] md;
    rst = ($urandom_range(7) != 0);
    jj  = 4'($urandom_range(15));
    kk  = 4'($urandom_range(15));
    md  = 2'($urandom_range(3));
    mn  = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
    reset = rst; j = jj; k = kk; mode = md; min_on = mn;
    q.push_back(model_step(rst, jj, kk, md, mn));
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int idx, logic [3:0] act, logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, req);
    end
  endtask

  // Monitor: outputs settle after each rising edge; compare on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n_popped++;
        chk("dout",   n_popped, dout,   e.dout);
        chk("rise",   n_popped, rise,   e.rise);
        chk("fall",   n_popped, fall,   e.fall);
        chk("locked", n_popped, locked, e.lock);
        chk("rise_fall_excl", n_popped, rise & fall, 4'b0000);
      end
    end
  end

  initial begin
    //    rst j      k      md    min    dout   rise   fall   lock
    // Reset with j asserted, then release with ch0 turn-on.
    dstep(0, 4'hF, 4'h0, 2'd0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    dstep(0, 4'hF, 4'h0, 2'd0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    dstep(1, 4'h1, 4'h0, 2'd0, 4'd0, 4'h1, 4'h1, 4'h0, 4'h0);
    dstep(1, 4'h0, 4'h0, 2'd0, 4'd0, 4'h1, 4'h0, 4'h0, 4'h0);
    // Mode 0 toggle on ch0.
    dstep(1, 4'h1, 4'h1, 2'd0, 4'd0, 4'h0, 4'h0, 4'h1, 4'h0);
    dstep(1, 4'h1, 4'h1, 2'd0, 4'd0, 4'h1, 4'h1, 4'h0, 4'h0);
    dstep(1, 4'h1, 4'h1, 2'd0, 4'd0, 4'h0, 4'h0, 4'h1, 4'h0);
    dstep(1, 4'h1, 4'h0, 2'd0, 4'd0, 4'h1, 4'h1, 4'h0, 4'h0);
    // Mode 3 holds ch0 on conflict.
    dstep(1, 4'h1, 4'h1, 2'd3, 4'd0, 4'h1, 4'h0, 4'h0, 4'h0);
    dstep(1, 4'h1, 4'h1, 2'd3, 4'd0, 4'h1, 4'h0, 4'h0, 4'h0);
    dstep(1, 4'h1, 4'h1, 2'd3, 4'd0, 4'h1, 4'h0, 4'h0, 4'h0);
    // Mode 1/2 conflicts on ch1.
    dstep(1, 4'h2, 4'h2, 2'd1, 4'd0, 4'h3, 4'h2, 4'h0, 4'h0);
    dstep(1, 4'h2, 4'h2, 2'd1, 4'd0, 4'h3, 4'h0, 4'h0, 4'h0);
    dstep(1, 4'h0, 4'h2, 2'd1, 4'd0, 4'h1, 4'h0, 4'h2, 4'h0);
    dstep(1, 4'h2, 4'h2, 2'd2, 4'd0, 4'h1, 4'h0, 4'h0, 4'h0);
    // Dwell on ch2: min_on=3, then k held; min_on changes mid-LOCK are ignored.
    dstep(1, 4'h4, 4'h0, 2'd0, 4'd3, 4'h5, 4'h4, 4'h0, 4'h4);
    dstep(1, 4'h0, 4'h4, 2'd0, 4'd9, 4'h5, 4'h0, 4'h0, 4'h4);
    dstep(1, 4'h0, 4'h4, 2'd0, 4'd9, 4'h5, 4'h0, 4'h0, 4'h4);
    dstep(1, 4'h0, 4'h4, 2'd0, 4'd9, 4'h5, 4'h0, 4'h0, 4'h0);
    dstep(1, 4'h0, 4'h4, 2'd0, 4'd0, 4'h1, 4'h0, 4'h4, 4'h0);
    dstep(1, 4'h0, 4'h4, 2'd0, 4'd0, 4'h1, 4'h0, 4'h0, 4'h0);
    // Reset in the middle of a long LOCK on ch3, then fresh re-entry.
    dstep(1, 4'h8, 4'h0, 2'd0, 4'd10, 4'h9, 4'h8, 4'h0, 4'h8);
    dstep(1, 4'h0, 4'h8, 2'd0, 4'd10, 4'h9, 4'h0, 4'h0, 4'h8);
    dstep(1, 4'h0, 4'h8, 2'd0, 4'd10, 4'h9, 4'h0, 4'h0, 4'h8);
    dstep(1, 4'h0, 4'h8, 2'd0, 4'd10, 4'h9, 4'h0, 4'h0, 4'h8);
    dstep(0, 4'hF, 4'h0, 2'd0, 4'd10, 4'h0, 4'h0, 4'h0, 4'h0);
    dstep(1, 4'h8, 4'h0, 2'd0, 4'd2, 4'h8, 4'h8, 4'h0, 4'h8);
    dstep(1, 4'h0, 4'h0, 2'd0, 4'd2, 4'h8, 4'h0, 4'h0, 4'h8);
    dstep(1, 4'h0, 4'h0, 2'd0, 4'd2, 4'h8, 4'h0, 4'h0, 4'h0);
    dstep(1, 4'h0, 4'h0, 2'd0, 4'd2, 4'h8, 4'h0, 4'h0, 4'h0);
    // Back-to-back fall then rise on ch3.
    dstep(1, 4'h0, 4'h8, 2'd0, 4'd0, 4'h0, 4'h0, 4'h8, 4'h0);
    dstep(1, 4'h8, 4'h0, 2'd0, 4'd0, 4'h8, 4'h8, 4'h0, 4'h0);
    dstep(1, 4'h0, 4'h0, 2'd0, 4'd0, 4'h8, 4'h0, 4'h0, 4'h0);
    // Maximum dwell on ch0: 15 LOCK cycles, then ON.
    dstep(1, 4'h1, 4'h8, 2'd0, 4'd15, 4'h1, 4'h1, 4'h8, 4'h1);
    for (int n = 0; n < 14; n++) begin
      dstep(1, 4'h0, 4'h1, 2'd0, 4'd0, 4'h1, 4'h0, 4'h0, 4'h1);
    end
    dstep(1, 4'h0, 4'h1, 2'd0, 4'd0, 4'h1, 4'h0, 4'h0, 4'h0);
    dstep(1, 4'h0, 4'h1, 2'd0, 4'd0, 4'h0, 4'h0, 4'h1, 4'h0);

    // Random phase against the behavioural model.
    for (int n = 0; n < 500; n++) begin
      rstep();
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int n = 0; n < 4 && q.size() > 0; n++) begin
      @(posedge clk);
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
